// File: rtl/recovery_controller_mp_pkg.sv
// Shared types for the recovery controller: writeback packet, FU codes,
// free-list checkpoint record and controller FSM states.
package buffer_pkgs;

  localparam int PREGS    = 64;
  localparam int PREG_W   = $clog2(PREGS);
  localparam int FL_CNT_W = $clog2(PREGS) + 1;
  localparam int WB_TAG_W = 4;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MEM = 2'd1;
  localparam logic [1:0] FU_BR  = 2'd2;
  localparam logic [1:0] FU_MUL = 2'd3;

  typedef struct packed {
    logic [WB_TAG_W-1:0] rob_tag;
    logic [1:0]          src_fu;
    logic                mispredict;
    logic [31:0]         dest_addr;
  } wb_packet_t;

  typedef struct packed {
    logic [PREG_W-1:0]   fl_head;
    logic [PREG_W-1:0]   fl_tail;
    logic [FL_CNT_W-1:0] fl_free_count;
  } rc_fl_chkpt_t;

  typedef enum logic {
    RC_IDLE,
    RC_HOLD
  } rc_state_e;

endpackage

// File: rtl/recovery_controller_mp_oldest_sel.sv
// Combinational oldest-entry selector: picks the valid channel whose ROB tag
// is closest to the head; ties resolve to the lowest channel.
module rc_oldest_sel #(
  parameter int NUM_WB = 2,
  parameter int TAG_W  = 4,
  parameter int IDX_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
  input  logic [NUM_WB-1:0]       valid_i,
  input  logic [NUM_WB*TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]        head_i,
  output logic [IDX_W-1:0]        win_idx_o,
  output logic                    win_valid_o
);

  logic [TAG_W-1:0] best_age;
  logic [TAG_W-1:0] age;

  always_comb begin
    win_idx_o   = '0;
    win_valid_o = 1'b0;
    best_age    = '1;
    age         = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      age = tags_i[k*TAG_W +: TAG_W] - head_i;
      // strict compare keeps the lower channel on equal age
      if (valid_i[k] && (!win_valid_o || (age < best_age))) begin
        win_valid_o = 1'b1;
        win_idx_o   = IDX_W'(k);
        best_age    = age;
      end
    end
  end

endmodule

// File: rtl/recovery_controller_mp.sv
// Branch-mispredict recovery controller with per-ROB-slot RAT/FL/ROB checkpoints.
// Optional RECOVERY_PERF_CNT_EN adds saturating recovery / checkpoint-miss counters.
module recovery_controller_mp
  import buffer_pkgs::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int AREG      = 32,
  parameter int PREGS     = buffer_pkgs::PREGS,
  parameter int PREG_W    = buffer_pkgs::PREG_W,
  parameter int NUM_WB    = 2,
  parameter int HOLD_CYC  = 2,
  localparam int TAG_W    = $clog2(ROB_DEPTH),
  localparam int MAP_W    = AREG * PREG_W,
  localparam int FLC_W    = $clog2(PREGS) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  wb_packet_t [NUM_WB-1:0] wb_packet_i,
  input  logic [TAG_W-1:0]        rob_head_i,
  input  logic                    ratfl_chkpt_we_i,
  input  logic [TAG_W-1:0]        ratfl_chkpt_tag_i,
  input  logic [MAP_W-1:0]        ratfl_chkpt_rat_map_i,
  input  logic [PREG_W-1:0]       ratfl_chkpt_fl_head_i,
  input  logic [PREG_W-1:0]       ratfl_chkpt_fl_tail_i,
  input  logic [FLC_W-1:0]        ratfl_chkpt_fl_free_count_i,
  input  logic                    rob_chkpt_we_i,
  input  logic [TAG_W-1:0]        rob_chkpt_tag_i,
  input  logic [TAG_W-1:0]        rob_chkpt_tail_i,
  input  logic [TAG_W:0]          rob_chkpt_used_i,
  input  logic                    commit_valid_i,
  input  logic [TAG_W-1:0]        commit_tag_i,
  output logic                    flush_o,
  output logic                    redirect_valid_o,
  output logic [31:0]             redirect_pc_o,
  output logic                    rob_recover_o,
  output logic [TAG_W-1:0]        rob_recover_tail_o,
  output logic [TAG_W:0]          rob_recover_used_o,
  output logic                    rat_recover_o,
  output logic [MAP_W-1:0]        rat_recover_map_o,
  output logic                    fl_recover_o,
  output logic [PREG_W-1:0]       fl_recover_head_o,
  output logic [PREG_W-1:0]       fl_recover_tail_o,
  output logic [FLC_W-1:0]        fl_recover_free_count_o,
  output logic [TAG_W-1:0]        recover_rob_tag_o,
  output logic                    rename_stall_o,
  output logic                    busy_o,
`ifdef RECOVERY_PERF_CNT_EN
  output logic [31:0]             recover_cnt_o,
  output logic [31:0]             chkpt_miss_cnt_o,
`endif
  output logic                    chkpt_miss_o
);

  localparam int IDX_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYC - 1);

  // checkpoint storage
  logic [MAP_W-1:0]     rat_map_q  [ROB_DEPTH];
  rc_fl_chkpt_t         fl_q       [ROB_DEPTH];
  logic [TAG_W-1:0]     rob_tail_q [ROB_DEPTH];
  logic [TAG_W:0]       rob_used_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] ratfl_v_q, ratfl_v_d;
  logic [ROB_DEPTH-1:0] rob_v_q, rob_v_d;

  rc_state_e       state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            pulse_q, miss_q;
  logic [TAG_W-1:0] rec_tag_q;

  logic [NUM_WB-1:0]       mp_valid;
  logic [NUM_WB*TAG_W-1:0] mp_tags;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_valid;
  logic [TAG_W-1:0]        win_tag;
  logic [31:0]             win_pc;
  logic [TAG_W-1:0]        win_age, rec_age;
  logic                    slot_hit, take, do_recover, do_miss;
  logic                    ratfl_we, rob_we;
  rc_fl_chkpt_t            win_fl;

  always_comb begin
    mp_valid = '0;
    mp_tags  = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      mp_valid[k] = wb_valid_i[k] && (wb_packet_i[k].src_fu == FU_BR)
                    && wb_packet_i[k].mispredict;
      mp_tags[k*TAG_W +: TAG_W] = TAG_W'(wb_packet_i[k].rob_tag);
    end
  end

  rc_oldest_sel #(
    .NUM_WB (NUM_WB),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W)
  ) u_oldest_sel (
    .valid_i     (mp_valid),
    .tags_i      (mp_tags),
    .head_i      (rob_head_i),
    .win_idx_o   (win_idx),
    .win_valid_o (win_valid)
  );

  assign win_tag  = mp_tags[win_idx*TAG_W +: TAG_W];
  assign win_pc   = wb_packet_i[win_idx].dest_addr;
  assign win_age  = win_tag - rob_head_i;
  assign rec_age  = rec_tag_q - rob_head_i;
  assign slot_hit = ratfl_v_q[win_tag] && rob_v_q[win_tag];
  assign win_fl   = fl_q[win_tag];

  // writes arriving while the recovery pulse is on the bus belong to the wrong path
  assign ratfl_we = ratfl_chkpt_we_i && !pulse_q;
  assign rob_we   = rob_chkpt_we_i && !pulse_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    do_recover = 1'b0;
    do_miss    = 1'b0;
    take       = win_valid && ((state_q == RC_IDLE) || (win_age < rec_age));
    if (take) begin
      if (slot_hit) do_recover = 1'b1;
      else          do_miss    = 1'b1;
    end
    if (do_recover) begin
      state_d    = RC_HOLD;
      hold_cnt_d = HOLD_INIT;
    end else if (state_q == RC_HOLD) begin
      if (hold_cnt_q == '0) state_d    = RC_IDLE;
      else                  hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  always_comb begin
    ratfl_v_d = ratfl_v_q;
    rob_v_d   = rob_v_q;
    if (commit_valid_i) begin
      ratfl_v_d[commit_tag_i] = 1'b0;
      rob_v_d[commit_tag_i]   = 1'b0;
    end
    if (ratfl_we) ratfl_v_d[ratfl_chkpt_tag_i] = 1'b1;
    if (rob_we)   rob_v_d[rob_chkpt_tag_i]     = 1'b1;
    if (do_recover) begin
      for (int unsigned s = 0; s < ROB_DEPTH; s++) begin
        if ((TAG_W'(s) - rob_head_i) > win_age) begin
          ratfl_v_d[s] = 1'b0;
          rob_v_d[s]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ratfl_we) begin
      rat_map_q[ratfl_chkpt_tag_i] <= ratfl_chkpt_rat_map_i;
      fl_q[ratfl_chkpt_tag_i]      <= '{fl_head:       ratfl_chkpt_fl_head_i,
                                        fl_tail:       ratfl_chkpt_fl_tail_i,
                                        fl_free_count: ratfl_chkpt_fl_free_count_i};
    end
    if (rob_we) begin
      rob_tail_q[rob_chkpt_tag_i] <= rob_chkpt_tail_i;
      rob_used_q[rob_chkpt_tag_i] <= rob_chkpt_used_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RC_IDLE;
      hold_cnt_q <= '0;
      ratfl_v_q  <= '0;
      rob_v_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ratfl_v_q  <= ratfl_v_d;
      rob_v_q    <= rob_v_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pulse_q                 <= 1'b0;
      miss_q                  <= 1'b0;
      rec_tag_q               <= '0;
      redirect_pc_o           <= '0;
      rob_recover_tail_o      <= '0;
      rob_recover_used_o      <= '0;
      rat_recover_map_o       <= '0;
      fl_recover_head_o       <= '0;
      fl_recover_tail_o       <= '0;
      fl_recover_free_count_o <= '0;
    end else begin
      pulse_q <= do_recover;
      miss_q  <= do_miss;
      if (do_recover) begin
        rec_tag_q               <= win_tag;
        redirect_pc_o           <= win_pc;
        rob_recover_tail_o      <= rob_tail_q[win_tag];
        rob_recover_used_o      <= rob_used_q[win_tag];
        rat_recover_map_o       <= rat_map_q[win_tag];
        fl_recover_head_o       <= win_fl.fl_head;
        fl_recover_tail_o       <= win_fl.fl_tail;
        fl_recover_free_count_o <= win_fl.fl_free_count;
      end
    end
  end

`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0] recover_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      recover_cnt_q <= '0;
      miss_cnt_q    <= '0;
    end else begin
      if (do_recover && (recover_cnt_q != '1)) recover_cnt_q <= recover_cnt_q + 1'b1;
      if (do_miss && (miss_cnt_q != '1))       miss_cnt_q    <= miss_cnt_q + 1'b1;
    end
  end

  assign recover_cnt_o    = recover_cnt_q;
  assign chkpt_miss_cnt_o = miss_cnt_q;
`endif

  assign flush_o           = pulse_q;
  assign redirect_valid_o  = pulse_q;
  assign rob_recover_o     = pulse_q;
  assign rat_recover_o     = pulse_q;
  assign fl_recover_o      = pulse_q;
  assign chkpt_miss_o      = miss_q;
  assign recover_rob_tag_o = rec_tag_q;
  assign rename_stall_o    = (state_q == RC_HOLD);
  assign busy_o            = (state_q == RC_HOLD);

endmodule

// File: tb/tb_recovery_controller_mp.sv
// Scoreboard bench for recovery_controller_mp: directed vectors push expected
// recovery/miss events; a negedge monitor pops and compares on each pulse.
module tb_recovery_controller_mp;
  import buffer_pkgs::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        wb_valid = '0;
  wb_packet_t [1:0]  wb_pkt = '0;
  logic [3:0]        head = '0;
  logic              r_we = 1'b0, b_we = 1'b0, c_v = 1'b0;
  logic [3:0]        r_tag = '0, b_tag = '0, c_tag = '0, b_tail = '0;
  logic [191:0]      r_map = '0;
  logic [5:0]        r_h = '0, r_t = '0;
  logic [6:0]        r_c = '0;
  logic [4:0]        b_used = '0;

  logic        flush, rv, rob_rec, rat_rec, fl_rec, stall, busy, miss;
  logic [31:0] rpc;
  logic [3:0]  rtail, rtag;
  logic [4:0]  rused;
  logic [191:0] rmap;
  logic [5:0]  fh, ft;
  logic [6:0]  fc;
`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0] rcnt, mcnt;
`endif

  recovery_controller_mp #(.ROB_DEPTH(16), .AREG(32), .NUM_WB(2), .HOLD_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid), .wb_packet_i(wb_pkt),
    .rob_head_i(head), .ratfl_chkpt_we_i(r_we), .ratfl_chkpt_tag_i(r_tag),
    .ratfl_chkpt_rat_map_i(r_map), .ratfl_chkpt_fl_head_i(r_h),
    .ratfl_chkpt_fl_tail_i(r_t), .ratfl_chkpt_fl_free_count_i(r_c),
    .rob_chkpt_we_i(b_we), .rob_chkpt_tag_i(b_tag), .rob_chkpt_tail_i(b_tail),
    .rob_chkpt_used_i(b_used), .commit_valid_i(c_v), .commit_tag_i(c_tag),
    .flush_o(flush), .redirect_valid_o(rv), .redirect_pc_o(rpc),
    .rob_recover_o(rob_rec), .rob_recover_tail_o(rtail), .rob_recover_used_o(rused),
    .rat_recover_o(rat_rec), .rat_recover_map_o(rmap), .fl_recover_o(fl_rec),
    .fl_recover_head_o(fh), .fl_recover_tail_o(ft), .fl_recover_free_count_o(fc),
    .recover_rob_tag_o(rtag), .rename_stall_o(stall), .busy_o(busy),
`ifdef RECOVERY_PERF_CNT_EN
    .recover_cnt_o(rcnt), .chkpt_miss_cnt_o(mcnt),
`endif
    .chkpt_miss_o(miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_miss;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [191:0] map;
    logic [5:0]  h, t;
    logic [6:0]  c;
    logic [3:0]  rt;
    logic [4:0]  u;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] s_seed [16];
  logic [5:0] s_h [16], s_t [16];
  logic [6:0] s_c [16];
  logic [3:0] s_rt [16];
  logic [4:0] s_u [16];

  function automatic logic [191:0] mk_map(input logic [7:0] s);
    return {24{s}};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [3:0] tag, input logic [7:0] seed, input logic [5:0] h,
                        input logic [5:0] t, input logic [6:0] c, input logic [3:0] rt,
                        input logic [4:0] u);
    r_we = 1'b1; r_tag = tag; r_map = mk_map(seed); r_h = h; r_t = t; r_c = c;
    b_we = 1'b1; b_tag = tag; b_tail = rt; b_used = u;
    s_seed[tag] = seed; s_h[tag] = h; s_t[tag] = t; s_c[tag] = c;
    s_rt[tag] = rt; s_u[tag] = u;
  endtask

  task automatic clr_wr();
    r_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] tag, input logic [7:0] seed, input logic [5:0] h,
                    input logic [5:0] t, input logic [6:0] c, input logic [3:0] rt,
                    input logic [4:0] u);
    set_wr(tag, seed, h, t, c, rt, u);
    cyc();
    clr_wr();
  endtask

  task automatic mp(input int ch, input logic [3:0] tag, input logic [31:0] pc);
    wb_valid[ch] = 1'b1;
    wb_pkt[ch] = '{rob_tag: tag, src_fu: FU_BR, mispredict: 1'b1, dest_addr: pc};
  endtask

  task automatic clr_wb();
    wb_valid = '0;
    wb_pkt = '0;
  endtask

  task automatic push_rec(input logic [3:0] tag, input logic [31:0] pc);
    exp_t e;
    e.is_miss = 1'b0; e.pc = pc; e.tag = tag; e.map = mk_map(s_seed[tag]);
    e.h = s_h[tag]; e.t = s_t[tag]; e.c = s_c[tag]; e.rt = s_rt[tag]; e.u = s_u[tag];
    exp_q.push_back(e);
  endtask

  task automatic push_miss();
    exp_t e;
    e = '{is_miss: 1'b1, pc: '0, tag: '0, map: '0, h: '0, t: '0, c: '0, rt: '0, u: '0};
    exp_q.push_back(e);
  endtask

  // monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && (flush || miss)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {flush, miss}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("flush", flush, !e.is_miss);
        chk("chkpt_miss", miss, e.is_miss);
        if (!e.is_miss) begin
          chk("recover_pulses", {rv, rob_rec, rat_rec, fl_rec}, 4'b1111);
          chk("redirect_pc", rpc, e.pc);
          chk("recover_tag", rtag, e.tag);
          chk("rat_map", rmap, e.map);
          chk("fl_head", fh, e.h);
          chk("fl_tail", ft, e.t);
          chk("fl_count", fc, e.c);
          chk("rob_tail", rtail, e.rt);
          chk("rob_used", rused, e.u);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(); cyc();
    chk("rst_flush", flush, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miss", miss, 1'b0);
    chk("rst_pc", rpc, 32'h0);
    chk("rst_map", rmap, 192'h0);
    rst = 1'b0;
    cyc();

    // basic recovery and two-cycle rename stall
    wr(4'd5, 8'h0A, 6'd3, 6'd9, 7'd20, 4'd6, 5'd4);
    mp(0, 4'd5, 32'h100); push_rec(4'd5, 32'h100);
    cyc(); clr_wb();
    chk("stall_n1", stall, 1'b1);
    chk("busy_n1", busy, 1'b1);
    cyc();
    chk("stall_n2", stall, 1'b1);
    cyc();
    chk("stall_n3", stall, 1'b0);
    chk("busy_n3", busy, 1'b0);
    chk("hold_pc", rpc, 32'h100);
    chk("hold_rob_tail", rtail, 4'd6);

    // mispredict flag from a non-branch unit is not a recovery
    wb_valid[0] = 1'b1;
    wb_pkt[0] = '{rob_tag: 4'd5, src_fu: FU_ALU, mispredict: 1'b1, dest_addr: 32'h500};
    cyc(); clr_wb(); cyc(); cyc();

    // oldest select across wrap: head 14, tag 15 older than tag 2
    head = 4'd14;
    wr(4'd2, 8'h22, 6'd1, 6'd2, 7'd3, 4'd4, 5'd5);
    wr(4'd15, 8'hF5, 6'd11, 6'd12, 7'd13, 4'd14, 5'd15);
    mp(0, 4'd2, 32'h200); mp(1, 4'd15, 32'h1500); push_rec(4'd15, 32'h1500);
    cyc(); clr_wb(); cyc(); cyc(); cyc();
    chk("wrap_tag", rtag, 4'd15);
    head = 4'd0;

    // restart on older mispredict during hold
    wr(4'd8, 8'h88, 6'd8, 6'd18, 7'd28, 4'd9, 5'd10);
    wr(4'd6, 8'h66, 6'd6, 6'd16, 7'd26, 4'd7, 5'd8);
    wr(4'd10, 8'hAA, 6'd10, 6'd20, 7'd30, 4'd11, 5'd12);
    mp(0, 4'd8, 32'h800); push_rec(4'd8, 32'h800);
    cyc(); clr_wb();
    mp(1, 4'd6, 32'h600); push_rec(4'd6, 32'h600);
    cyc(); clr_wb();
    cyc();
    chk("restart_stall_ext", stall, 1'b1);
    cyc();
    chk("restart_stall_end", stall, 1'b0);

    // younger mispredict during hold is ignored
    wr(4'd8, 8'h89, 6'd7, 6'd17, 7'd27, 4'd3, 5'd2);
    mp(0, 4'd8, 32'h880); push_rec(4'd8, 32'h880);
    cyc(); clr_wb();
    mp(0, 4'd10, 32'hA00);
    cyc(); clr_wb();
    cyc();
    chk("ignore_stall_end", stall, 1'b0);
    cyc();

    // commit releases slot -> miss; write beats same-cycle commit
    wr(4'd3, 8'h33, 6'd31, 6'd32, 7'd33, 4'd2, 5'd1);
    c_v = 1'b1; c_tag = 4'd3;
    cyc(); c_v = 1'b0;
    mp(0, 4'd3, 32'h300); push_miss();
    cyc(); clr_wb();
    chk("miss_busy", busy, 1'b0);
    cyc();
    set_wr(4'd3, 8'h3C, 6'd41, 6'd42, 7'd43, 4'd12, 5'd13);
    c_v = 1'b1; c_tag = 4'd3;
    cyc(); c_v = 1'b0; clr_wr();
    mp(0, 4'd3, 32'h330); push_rec(4'd3, 32'h330);
    cyc(); clr_wb(); cyc(); cyc(); cyc();

    // write in pulse cycle dropped; younger slots invalidated, recovered slot kept
    wr(4'd1, 8'h11, 6'd21, 6'd22, 7'd23, 4'd1, 5'd16);
    mp(0, 4'd1, 32'h110); push_rec(4'd1, 32'h110);
    cyc(); clr_wb();
    set_wr(4'd12, 8'hCC, 6'd12, 6'd12, 7'd12, 4'd12, 5'd12);
    cyc(); clr_wr(); cyc();
    mp(0, 4'd12, 32'hC00); push_miss();
    cyc(); clr_wb(); cyc();
    mp(0, 4'd3, 32'h333); push_miss();
    cyc(); clr_wb(); cyc();
    mp(0, 4'd1, 32'h111); push_rec(4'd1, 32'h111);
    cyc(); clr_wb(); cyc(); cyc(); cyc();

    // asynchronous reset in first hold cycle
    wr(4'd7, 8'h77, 6'd17, 6'd27, 7'd37, 4'd5, 5'd6);
    mp(0, 4'd7, 32'h700);
    cyc(); clr_wb();
    rst = 1'b1;
    #1;
    chk("arst_stall", stall, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_flush", flush, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    mp(0, 4'd7, 32'h701); push_miss();
    cyc(); clr_wb(); cyc();
    mp(1, 4'd1, 32'h101); push_miss();
    cyc(); clr_wb(); cyc(); cyc();

    chk("queue_drained", 192'(exp_q.size()), 192'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
